// File: rtl/reg_access_arb_if.sv
// Bundle of the two requester ports and the shared register-file port of
// reg_access_arb. The arbiter takes the slave view; the requesters and the
// register file together form the master view.
interface reg_access_arb_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    // requester 0
    logic            req0_cs;
    logic            req0_rnw;
    logic [AW-1:0]   req0_addr;
    logic [DW-1:0]   req0_data;
    logic [DW/8-1:0] req0_be;
    logic            req0_rdack;
    logic            req0_wrack;
    logic [DW-1:0]   req0_rdata;
    logic            req0_error;
    // requester 1
    logic            req1_cs;
    logic            req1_rnw;
    logic [AW-1:0]   req1_addr;
    logic [DW-1:0]   req1_data;
    logic [DW/8-1:0] req1_be;
    logic            req1_rdack;
    logic            req1_wrack;
    logic [DW-1:0]   req1_rdata;
    logic            req1_error;
    // shared register-file port
    logic            reg_cs;
    logic            reg_rnw;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_data;
    logic [DW/8-1:0] reg_be;
    logic [DW-1:0]   reg_rdata;
    logic            reg_rdack;
    logic            reg_wrack;

    modport slave (
        input  req0_cs, req0_rnw, req0_addr, req0_data, req0_be,
        output req0_rdack, req0_wrack, req0_rdata, req0_error,
        input  req1_cs, req1_rnw, req1_addr, req1_data, req1_be,
        output req1_rdack, req1_wrack, req1_rdata, req1_error,
        output reg_cs, reg_rnw, reg_addr, reg_data, reg_be,
        input  reg_rdata, reg_rdack, reg_wrack
    );

    modport master (
        output req0_cs, req0_rnw, req0_addr, req0_data, req0_be,
        input  req0_rdack, req0_wrack, req0_rdata, req0_error,
        output req1_cs, req1_rnw, req1_addr, req1_data, req1_be,
        input  req1_rdack, req1_wrack, req1_rdata, req1_error,
        input  reg_cs, reg_rnw, reg_addr, reg_data, reg_be,
        output reg_rdata, reg_rdack, reg_wrack
    );
endinterface

// File: rtl/reg_access_arb.sv
// Two-requester round-robin arbiter in front of a single register-file port.
// One transaction at a time: IDLE -> ISSUE (one reg_cs pulse) -> WAIT (for
// the ack of the matching type) -> RESP (one-cycle ack to the winner).
// Optional feature macro ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with
// error=1 and rdata=DEADBEEF. Without it WAIT lasts until the ack arrives and
// the error outputs are tied low.
module reg_access_arb #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input logic             clk,
    input logic             resetn,
    reg_access_arb_if.slave bus
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // requester inputs gathered into indexable form
    logic [1:0]    w_cs;
    logic [1:0]    w_rnw;
    logic [AW-1:0] w_addr [2];
    logic [DW-1:0] w_data [2];
    logic [BW-1:0] w_be   [2];
    logic [1:0]    w_elig;
    logic          w_pick;
    logic          w_hit;

    state_t        r_state;
    logic          r_win;
    logic          r_last;
    logic [1:0]    r_elig;
    logic [1:0]    r_rdack;
    logic [1:0]    r_wrack;
    logic [DW-1:0] r_rdata [2];
    logic          r_reg_cs;
    logic          r_reg_rnw;
    logic [AW-1:0] r_reg_addr;
    logic [DW-1:0] r_reg_data;
    logic [BW-1:0] r_reg_be;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic [1:0]    r_error;
    logic          w_tmo;
    // last WAIT cycle that may still accept an ack
    assign w_tmo = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    assign w_cs      = {bus.req1_cs, bus.req0_cs};
    assign w_rnw     = {bus.req1_rnw, bus.req0_rnw};
    assign w_addr[0] = bus.req0_addr;
    assign w_addr[1] = bus.req1_addr;
    assign w_data[0] = bus.req0_data;
    assign w_data[1] = bus.req1_data;
    assign w_be[0]   = bus.req0_be;
    assign w_be[1]   = bus.req1_be;

    assign w_elig = w_cs & r_elig;
    // On contention the requester not served last wins; r_last resets to 1 so
    // requester 0 goes first after reset.
    assign w_pick = (&w_elig) ? ~r_last : w_elig[1];
    // Only the ack type matching the latched direction completes the access.
    assign w_hit  = r_reg_rnw ? bus.reg_rdack : bus.reg_wrack;

    // Arbitration FSM with registered requester-side and register-side outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_win      <= 1'b0;
            r_last     <= 1'b1;
            r_elig     <= 2'b11;
            r_rdack    <= '0;
            r_wrack    <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_reg_cs   <= 1'b0;
            r_reg_rnw  <= 1'b1;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_reg_be   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_error    <= '0;
            r_tmo_cnt  <= '0;
`endif
        end else begin
            // response pulses and reg_cs last exactly one cycle
            r_rdack    <= '0;
            r_wrack    <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_reg_cs   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_error    <= '0;
`endif
            // Seeing cs low re-arms a requester; the clear on ack below wins.
            for (int i = 0; i < 2; i++) begin
                if (!w_cs[i]) r_elig[i] <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_win      <= w_pick;
                        r_last     <= w_pick;
                        r_reg_rnw  <= w_rnw[w_pick];
                        r_reg_addr <= w_addr[w_pick];
                        r_reg_data <= w_data[w_pick];
                        r_reg_be   <= w_be[w_pick];
                        r_reg_cs   <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (w_hit) begin
                        r_rdack[r_win] <= r_reg_rnw;
                        r_wrack[r_win] <= ~r_reg_rnw;
                        r_rdata[r_win] <= bus.reg_rdata;
                        r_elig[r_win]  <= 1'b0;
                        r_state        <= RESP;
`ifdef ARB_TIMEOUT_EN
                        r_tmo_cnt      <= '0;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_rdack[r_win] <= r_reg_rnw;
                        r_wrack[r_win] <= ~r_reg_rnw;
                        r_rdata[r_win] <= DW'(32'hDEADBEEF);
                        r_error[r_win] <= 1'b1;
                        r_elig[r_win]  <= 1'b0;
                        r_tmo_cnt      <= '0;
                        r_state        <= RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CW'(1);
                    end
`endif
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_rdack = r_rdack[0];
    assign bus.req0_wrack = r_wrack[0];
    assign bus.req0_rdata = r_rdata[0];
    assign bus.req1_rdack = r_rdack[1];
    assign bus.req1_wrack = r_wrack[1];
    assign bus.req1_rdata = r_rdata[1];
`ifdef ARB_TIMEOUT_EN
    assign bus.req0_error = r_error[0];
    assign bus.req1_error = r_error[1];
`else
    assign bus.req0_error = 1'b0;
    assign bus.req1_error = 1'b0;
`endif

    assign bus.reg_cs   = r_reg_cs;
    assign bus.reg_rnw  = r_reg_rnw;
    assign bus.reg_addr = r_reg_addr;
    assign bus.reg_data = r_reg_data;
    assign bus.reg_be   = r_reg_be;
endmodule

// File: tb/tb_reg_access_arb.sv
// Scoreboard bench for reg_access_arb: requester drivers push each request
// into a per-requester queue; a negedge monitor predicts the round-robin
// winner, checks the register-side access, and checks the response pulse
// (owner, type, data, error, timing) against the reference rules.
module tb_reg_access_arb;
    localparam int TO = 16;

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    reg_access_arb_if #(.DW(32), .AW(32)) bus ();

    reg_access_arb #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    // register-file responder controls
    bit noack = 0;
    bit quiet = 1;
    bit wrong_first = 0;
    int force_d = 0;

    req_t q0[$];
    req_t q1[$];

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a * 32'h123 + 32'h4;
    endfunction

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_cs(input int n, input logic v);
        if (n == 0) bus.req0_cs = v; else bus.req1_cs = v;
    endtask

    task automatic put_req(input int n, input bit rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.rnw = rnw; r.addr = a; r.data = d; r.be = be;
        if (n == 0) begin
            bus.req0_rnw = rnw; bus.req0_addr = a; bus.req0_data = d; bus.req0_be = be; bus.req0_cs = 1'b1;
            q0.push_back(r);
        end else begin
            bus.req1_rnw = rnw; bus.req1_addr = a; bus.req1_data = d; bus.req1_be = be; bus.req1_cs = 1'b1;
            q1.push_back(r);
        end
    endtask

    task automatic issue(input int n, input bit rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        put_req(n, rnw, a, d, be);
    endtask

    task automatic wait_ack(input int n, input bit drop);
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = (n == 0) ? (bus.req0_rdack | bus.req0_wrack) : (bus.req1_rdack | bus.req1_wrack);
        end
        check(got, $sformatf("ack_wait_req%0d", n), {31'd0, got}, 32'd1);
        if (drop) begin
            @(posedge clk); #1;
            set_cs(n, 1'b0);
        end
    endtask

    task automatic wait_regcs();
        bit got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.reg_cs;
        end
        check(got, "reg_cs_wait", {31'd0, got}, 32'd1);
    endtask

    task automatic chk_rst(input string tag);
        check(bus.reg_cs == 1'b0, {tag, "_reg_cs"}, {31'd0, bus.reg_cs}, 32'd0);
        check(bus.reg_rnw == 1'b1, {tag, "_reg_rnw"}, {31'd0, bus.reg_rnw}, 32'd1);
        check(bus.reg_addr == 32'd0, {tag, "_reg_addr"}, bus.reg_addr, 32'd0);
        check(bus.reg_data == 32'd0, {tag, "_reg_data"}, bus.reg_data, 32'd0);
        check(bus.reg_be == 4'd0, {tag, "_reg_be"}, {28'd0, bus.reg_be}, 32'd0);
        check({bus.req0_rdack, bus.req0_wrack, bus.req1_rdack, bus.req1_wrack,
               bus.req0_error, bus.req1_error} == 6'd0, {tag, "_acks"},
              {26'd0, bus.req0_rdack, bus.req0_wrack, bus.req1_rdack, bus.req1_wrack,
               bus.req0_error, bus.req1_error}, 32'd0);
        check((bus.req0_rdata | bus.req1_rdata) == 32'd0, {tag, "_rdata"},
              bus.req0_rdata | bus.req1_rdata, 32'd0);
    endtask

    task automatic rand_req(input int n, input int cnt);
        repeat (cnt) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(n, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)));
            wait_ack(n, 1'b1);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    bit          infl = 0;
    int          infl_n = 0;
    bit          infl_rnw = 0;
    int          cs_cyc = 0;
    int          exp_ack_cyc = -1;
    logic [31:0] exp_rdata = '0;
    int          tb_last = 1;
    logic [1:0]  tb_elig = 2'b11;
    logic [1:0]  snap = 2'b00;
    bit          prev_cs = 0;

    always @(negedge clk) begin
        logic [1:0]  rda, wra, er, csv;
        logic [31:0] rdv [2];
        int          e_cyc, w;
        logic [31:0] e_rd;
        logic        e_er;
        req_t        r;
        if (!resetn) begin
            infl = 0; tb_last = 1; tb_elig = 2'b11; snap = 2'b00; prev_cs = 0;
            exp_ack_cyc = -1;
            q0.delete(); q1.delete();
        end else begin
            cyc++;
            rda = {bus.req1_rdack, bus.req0_rdack};
            wra = {bus.req1_wrack, bus.req0_wrack};
            er  = {bus.req1_error, bus.req0_error};
            csv = {bus.req1_cs, bus.req0_cs};
            rdv[0] = bus.req0_rdata;
            rdv[1] = bus.req1_rdata;
            for (int n = 0; n < 2; n++) begin
                if (!(rda[n] | wra[n])) begin
                    check(rdv[n] == 32'd0 && er[n] == 1'b0, $sformatf("idle_out_req%0d", n),
                          rdv[n] | {31'd0, er[n]}, 32'd0);
                end else begin
                    check(infl && infl_n == n && !(rda[n] & wra[n]), $sformatf("ack_owner_req%0d", n),
                          n, infl ? infl_n : -1);
                    if (infl && infl_n == n) begin
                        if (exp_ack_cyc < 0) begin
`ifdef ARB_TIMEOUT_EN
                            e_cyc = cs_cyc + 1 + TO; e_rd = 32'hDEADBEEF; e_er = 1'b1;
`else
                            e_cyc = -1; e_rd = exp_rdata; e_er = 1'b0;
`endif
                        end else begin
                            e_cyc = exp_ack_cyc; e_rd = exp_rdata; e_er = 1'b0;
                        end
                        check(cyc == e_cyc, "ack_latency", cyc, e_cyc);
                        check(rda[n] == infl_rnw, "ack_type", {31'd0, rda[n]}, {31'd0, infl_rnw});
                        check(rdv[n] == e_rd, "ack_rdata", rdv[n], e_rd);
                        check(er[n] == e_er, "ack_error", {31'd0, er[n]}, {31'd0, e_er});
                        infl = 0;
                        tb_elig[n] = 1'b0;
                    end
                end
            end
            // register-file ack of the direction the transaction waits for
            if (infl && cyc > cs_cyc && exp_ack_cyc < 0 && (infl_rnw ? bus.reg_rdack : bus.reg_wrack))
                exp_ack_cyc = cyc + 1;
            if (bus.reg_cs) begin
                check(!prev_cs, "reg_cs_single", 32'd1, 32'd0);
                check(!infl, "grant_while_busy", {31'd0, infl}, 32'd0);
                check(snap != 2'b00, "spurious_grant", {30'd0, snap}, 32'd1);
                if (snap != 2'b00) begin
                    w = (snap == 2'b11) ? (1 - tb_last) : (snap[1] ? 1 : 0);
                    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                        check(1'b0, "grant_queue_empty", w, 32'd0);
                    end else begin
                        r = (w == 0) ? q0.pop_front() : q1.pop_front();
                        check(bus.reg_rnw == r.rnw, $sformatf("reg_rnw_req%0d", w), {31'd0, bus.reg_rnw}, {31'd0, r.rnw});
                        check(bus.reg_addr == r.addr, $sformatf("reg_addr_req%0d", w), bus.reg_addr, r.addr);
                        check(bus.reg_data == r.data, $sformatf("reg_data_req%0d", w), bus.reg_data, r.data);
                        check(bus.reg_be == r.be, $sformatf("reg_be_req%0d", w), {28'd0, bus.reg_be}, {28'd0, r.be});
                        infl = 1; infl_n = w; infl_rnw = r.rnw; cs_cyc = cyc; exp_ack_cyc = -1;
                        exp_rdata = r.rnw ? rd_fn(r.addr) : 32'd0;
                        tb_last = w;
                    end
                end
            end
            prev_cs = bus.reg_cs;
            for (int n = 0; n < 2; n++) if (!csv[n]) tb_elig[n] = 1'b1;
            snap = csv & tb_elig;
        end
    end

    // ---------------- register-file responder ----------------
    initial begin
        bit          rnw, spur;
        logic [31:0] addr;
        int          d;
        forever begin
            @(negedge clk);
            if (resetn && bus.reg_cs && !noack) begin
                rnw  = bus.reg_rnw;
                addr = bus.reg_addr;
                d    = (force_d != 0) ? force_d : int'($urandom_range(1, 5));
                spur = wrong_first || (!quiet && $urandom_range(0, 3) == 0);
                @(posedge clk); #1;
                if (spur) begin
                    if (rnw) bus.reg_wrack = 1'b1; else bus.reg_rdack = 1'b1;
                    bus.reg_rdata = 32'hBAD00BAD;
                    @(posedge clk); #1;
                    bus.reg_rdack = 1'b0; bus.reg_wrack = 1'b0; bus.reg_rdata = '0;
                    repeat (wrong_first ? 2 : int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
                end else begin
                    repeat (d - 1) begin @(posedge clk); #1; end
                end
                if (rnw) begin bus.reg_rdack = 1'b1; bus.reg_rdata = rd_fn(addr); end
                else bus.reg_wrack = 1'b1;
                @(posedge clk); #1;
                bus.reg_rdack = 1'b0; bus.reg_wrack = 1'b0; bus.reg_rdata = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cnt;
        bus.req0_cs = 0; bus.req0_rnw = 0; bus.req0_addr = '0; bus.req0_data = '0; bus.req0_be = '0;
        bus.req1_cs = 0; bus.req1_rnw = 0; bus.req1_addr = '0; bus.req1_data = '0; bus.req1_be = '0;
        bus.reg_rdata = '0; bus.reg_rdack = 0; bus.reg_wrack = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1 chk_rst("reset");
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        // simultaneous writes: requester 0 first after reset, then requester 1
        @(posedge clk); #1;
        put_req(0, 1'b0, 32'h40, 32'hA, 4'hF);
        put_req(1, 1'b0, 32'h44, 32'hB, 4'hF);
        fork
            wait_ack(0, 1'b1);
            wait_ack(1, 1'b1);
        join

        // read of 0x10, register file answers two cycles after reg_cs with 0x1234
        force_d = 2;
        issue(0, 1'b1, 32'h10, 32'h0, 4'hF);
        wait_ack(0, 1'b1);
        force_d = 0;

        // requester 1 keeps cs high after its ack: no re-grant until cs drops
        issue(1, 1'b0, 32'h80, 32'h55AA, 4'h3);
        wait_ack(1, 1'b0);
        cnt = 0;
        repeat (12) begin @(negedge clk); if (bus.reg_cs) cnt++; end
        check(cnt == 0, "held_cs_no_regrant", cnt, 32'd0);
        @(posedge clk); #1 set_cs(1, 1'b0);
        issue(1, 1'b1, 32'h84, 32'h0, 4'hF);
        wait_ack(1, 1'b1);

        // cs dropped while granted: ack still delivered
        issue(0, 1'b1, 32'h44, 32'h0, 4'hF);
        wait_regcs();
        @(posedge clk); #1 set_cs(0, 1'b0);
        wait_ack(0, 1'b0);

        // write sees a stray rdack first, then wrack three cycles later
        wrong_first = 1;
        issue(0, 1'b0, 32'h90, 32'hCAFE, 4'hC);
        wait_ack(0, 1'b1);
        wrong_first = 0;

`ifdef ARB_TIMEOUT_EN
        // register file never answers: timeout response, then normal service
        noack = 1;
        issue(0, 1'b1, 32'h30, 32'h0, 4'hF);
        wait_ack(0, 1'b1);
        noack = 0;
        issue(1, 1'b1, 32'h34, 32'h0, 4'hF);
        wait_ack(1, 1'b1);
`endif

        // reset in the middle of WAIT drops the access without an ack
        noack = 1;
        issue(0, 1'b1, 32'h20, 32'h0, 4'hF);
        wait_regcs();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk_rst("midreset");
        set_cs(0, 1'b0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        noack = 0;
        @(posedge clk); #1;
        put_req(0, 1'b1, 32'h24, 32'h0, 4'hF);
        put_req(1, 1'b1, 32'h28, 32'h0, 4'hF);
        fork
            wait_ack(0, 1'b1);
            wait_ack(1, 1'b1);
        join

        // randomized traffic from both requesters
        quiet = 0;
        fork
            rand_req(0, 40);
            rand_req(1, 40);
        join
        repeat (10) @(posedge clk);
        check(q0.size() == 0 && q1.size() == 0 && !infl, "drain_empty",
              q0.size() + q1.size() + int'(infl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/reg_access_arb.md
REG_ACCESS_ARB -- requirements
Module: reg_access_arb

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: data width of all data ports.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 32: address width of all address ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: cycles the block waits for an ack before abort (used only with ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 reqN_cs  in  1  requester N (N=0,1) access request; held high until ack.
REQ-007 reqN_rnw  in  1  1=read, 0=write.
REQ-008 reqN_addr  in  ADDR  register address.
REQ-009 reqN_data  in  DATA  write data.
REQ-010 reqN_be  in  DATA/8  byte enables.
REQ-011 reqN_rdack / reqN_wrack  out  1  one-cycle completion pulse to requester N.
REQ-012 reqN_rdata  out  DATA  read data, valid with reqN_rdack.
REQ-013 reqN_error  out  1  error flag, valid with either ack.
REQ-014 reg_cs, reg_rnw, reg_addr, reg_data, reg_be  out  1/1/ADDR/DATA/DATA/8  shared register-file access port.
REQ-015 reg_rdata  in  DATA; reg_rdack, reg_wrack  in  1  register-file response.

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any eligible request, SHALL grant one and go to ISSUE next cycle; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: when both eligible, grant the requester not granted last; after reset, requester 0 has priority.
REQ-019 On grant, rnw/addr/data/be of the winner SHALL be latched; reg_* outputs driven from latched values only.
REQ-020 ISSUE: reg_cs SHALL be 1 for exactly one cycle, then WAIT.
REQ-021 WAIT: on reg_rdack (read) or reg_wrack (write), SHALL capture reg_rdata and go to RESP; acks of the wrong type SHALL be ignored.
REQ-022 RESP: winner's matching ack SHALL pulse high one cycle with captured rdata and error; then IDLE.
REQ-023 Grant-to-ack latency SHALL be 3 cycles plus register-file ack latency.
REQ-024 A requester SHALL become ineligible after its ack and eligible again only after its cs has been sampled low at least once.
REQ-025 A requester's cs falling while granted SHALL NOT abort the transaction; the ack is still issued.
REQ-026 Non-granted requester outputs SHALL be 0; reqN_rdata SHALL be 0 except in the ack cycle.

Reset
REQ-027 On resetn low, asynchronously: state=IDLE, all acks/error/reg_cs=0, rdata/reg_addr/reg_data/reg_be=0, reg_rnw=1, last-grant=1, both requesters eligible, timeout counter=0.
REQ-028 Reset mid-transaction SHALL drop the transaction with no ack issued.

Configuration
REQ-029 With ARB_TIMEOUT_EN defined: counter SHALL count cycles in WAIT; at TIMEOUT_CYCLES without ack, go to RESP with error=1 and rdata=32'hDEADBEEF; the counter SHALL clear on leaving WAIT.
REQ-030 Without ARB_TIMEOUT_EN: WAIT SHALL persist until ack; reqN_error SHALL be constant 0; no counter logic.

Verification
REQ-031 Req0 read addr 0x10, reg_rdack 2 cycles after reg_cs with rdata 0x1234 -> req0_rdack single pulse, req0_rdata=0x1234, error=0, req1 outputs 0.
REQ-032 Req0 and req1 raise cs same cycle (writes, data 0xA / 0xB) -> req0 served first, reg_data=0xA, then req1 with reg_data=0xB, one reg_cs pulse each.
REQ-033 Req1 holds cs high after ack while req0 idle -> no second transaction until req1 cs low then high again.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, register file never acks read -> ack 16 cycles into WAIT with error=1, rdata=0xDEADBEEF; next request served normally.
REQ-035 resetn asserted during WAIT -> outputs at reset values immediately, no ack; after release req0 request served normally with req0 priority.
REQ-036 Write in WAIT receives reg_rdack only, then reg_wrack 3 cycles later -> req wrack issued only after reg_wrack.
